seq_frac_divider: RTL and testbench
===================================

# seq_frac_divider

Parametrised multi-cycle restoring divider for the synthesizer datapath. It computes the fixed-point ratio floor(dividend·2^QW / divisor), for example a phase count over a note period giving an 8-bit wavetable position. It generalises the earlier fixed 16/8-bit divider with:
- configurable widths,
- a start/ready/valid handshake,
- a remainder output,
- explicit divide-by-zero and overflow (saturation) flags,
- a fixed, documented latency.

## Interface
Parameters:
- DW, 16: dividend/divisor width (≥2).
- QW, 8: quotient width, i.e. fractional bits of the result (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  request; accepted on a rising edge where start && start_ready.
- dividend  in  DW  unsigned numerator; sampled on acceptance only.
- divisor  in  DW  unsigned denominator; sampled on acceptance only.
- start_ready  out  1  high only in IDLE.
- busy  out  1  high in CALC and DONE.
- result_valid  out  1  one-cycle pulse when results update.
- quotient  out  QW  result; held until the next completion.
- remainder  out  DW  final partial remainder (unscaled); held.
- div_by_zero  out  1  divisor was 0 for the held result.
- overflow  out  1  dividend ≥ divisor (nonzero) for the held result.

## Operation
- FSM states are IDLE, CALC and DONE.
- Reset (rst=1 at an edge) forces IDLE regardless of state, aborting any division. It zeroes quotient, remainder, flags, result_valid and busy; start_ready=1 after reset.
- **IDLE, on acceptance:**
  - Load rem (DW+1 bits) = dividend, D = divisor, q = 0, cnt = QW.
  - Latch special-case flags: dz = (divisor==0); ov = (!dz && dividend ≥ divisor).
  - Go to CALC.
- **CALC, each cycle:**
  - rem' = rem<<1.
  - If rem' ≥ D: rem = rem'−D and shift 1 into q LSB; else rem = rem' and shift 0.
  - cnt decrements; when cnt reaches 1 at an edge, go to DONE.
  - CALC always lasts exactly QW cycles, even when dz or ov is set, giving a fixed latency.
- **DONE** (one cycle): register the outputs, pulse result_valid, then go to IDLE.
  - dz: quotient = all ones, remainder = 0, div_by_zero = 1, overflow = 0.
  - ov: quotient = all ones, remainder = 0, overflow = 1.
  - Otherwise: quotient = q, remainder = rem[DW-1:0], both flags 0.
- start is ignored while busy (not queued). dividend and divisor may change freely after acceptance.
- In the normal case the invariants hold: remainder < divisor and dividend·2^QW = quotient·divisor + remainder.

## Timing
- Acceptance edge k, CALC edges k+1..k+QW, DONE edge k+QW+1.
- After edge k+QW+1, outputs show new values and result_valid=1 for exactly one cycle.
- start_ready returns to 1 in that same cycle, so a back-to-back start can be accepted at edge k+QW+2.
- Throughput is one division per QW+2 cycles. Latency is QW+1 edges from acceptance to visible result.
- Outputs are held, not cleared, between results and during a new computation.
- rst asserted on the same edge as start: reset wins, and nothing is accepted.

## Structure
- Shared package synth_div_pkg holds:
  - the state typedef (IDLE/CALC/DONE),
  - default DW/QW localparams,
  - a saturated-quotient constant helper.
- One natural sub-module, frac_div_step: a purely combinational, parametrised single restoring step (rem, D → next rem, quotient bit). It is instantiated once in the top and reusable by a future unrolled/pipelined variant.
- The top module holds the FSM, counter, operand, accumulator and output registers. Expected size is about 150–250 lines of RTL.

## Test plan
All scenarios use DW=16, QW=8.
- Reset: rst high for 2 edges, including mid-CALC of a running division → all outputs 0, start_ready=1, no result_valid pulse follows.
- 22000/22727, accepted at edge k → result_valid only after edge k+9, quotient=247, remainder=18431, flags 0. Repeat with 11363/22727 → quotient=127, remainder=22599.
- 22727/22727 → quotient=255, remainder=0, overflow=1. Then 0/22727 → quotient=0, remainder=0, overflow=0.
- 1000/0 → quotient=255, remainder=0, div_by_zero=1, latency still 9 edges.
- start held high continuously, operands changed during busy → results match the operands sampled at acceptance only. Acceptances occur every 10 edges, and exactly one result_valid pulse appears per acceptance.
- Random sweep of 1000 operand pairs against a reference model (floor(N·256/D), with saturation and flags) → every result matches.

Source files
------------

// File: rtl/synth_div_pkg.sv
// Shared types and constants for the synthesizer fractional divider.
package synth_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_DW = 16;
  localparam int DEF_QW = 8;

  // All-ones quotient of width qw (saturated result), up to 32 bits.
  function automatic logic [31:0] sat_quot(input int qw);
    if (qw >= 32) return '1;
    return (32'd1 << qw) - 32'd1;
  endfunction

endpackage

// File: rtl/frac_div_step.sv
// One combinational restoring-division step: shift the partial remainder
// left by one and subtract the divisor when it fits.
module frac_div_step #(
  parameter int DW = 16
) (
  input  logic [DW:0]   rem_i,
  input  logic [DW-1:0] den_i,
  output logic [DW:0]   rem_o,
  output logic          qbit_o
);

  logic [DW+1:0] shifted;
  logic [DW:0]   diff;

  // The low DW+1 bits of the modular difference equal the true difference
  // whenever the subtraction is taken, so the shifted-out MSB is not needed.
  always_comb begin
    shifted = {rem_i, 1'b0};
    qbit_o  = (shifted >= {2'b00, den_i});
    diff    = shifted[DW:0] - {1'b0, den_i};
    rem_o   = qbit_o ? diff : shifted[DW:0];
  end

endmodule

// File: rtl/seq_frac_divider.sv
// Multi-cycle restoring divider producing floor(dividend*2^QW / divisor)
// with a start/ready handshake, remainder, and saturation flags.
module seq_frac_divider
  import synth_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int QW = DEF_QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          start_ready,
  output logic          busy,
  output logic          result_valid,
  output logic [QW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int            CW   = $clog2(QW + 1);
  localparam logic [QW-1:0] QSAT = QW'(sat_quot(QW));

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   rem_q, rem_d;
  logic [DW-1:0] den_q, den_d;
  logic [QW-1:0] acc_q, acc_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic [QW-1:0] quot_q, quot_d;
  logic [DW-1:0] remo_q, remo_d;
  logic          dzo_q, dzo_d;
  logic          ovo_q, ovo_d;
  logic          rv_q, rv_d;

  logic [DW:0]   step_rem;
  logic          step_qbit;

  frac_div_step #(.DW(DW)) u_step (
    .rem_i  (rem_q),
    .den_i  (den_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    den_d   = den_q;
    acc_d   = acc_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dzo_d   = dzo_q;
    ovo_d   = ovo_q;
    rv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = {1'b0, dividend};
          den_d   = divisor;
          acc_d   = '0;
          cnt_d   = CW'(QW);
          dz_d    = (divisor == '0);
          ov_d    = (divisor != '0) && (dividend >= divisor);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Runs the full QW steps even for special cases to keep latency fixed.
        rem_d = step_rem;
        acc_d = QW'({acc_q, step_qbit});
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        rv_d    = 1'b1;
        state_d = ST_IDLE;
        if (dz_q) begin
          quot_d = QSAT;
          remo_d = '0;
          dzo_d  = 1'b1;
          ovo_d  = 1'b0;
        end else if (ov_q) begin
          quot_d = QSAT;
          remo_d = '0;
          dzo_d  = 1'b0;
          ovo_d  = 1'b1;
        end else begin
          quot_d = acc_q;
          remo_d = rem_q[DW-1:0];
          dzo_d  = 1'b0;
          ovo_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and visible outputs; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rv_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
    end
  end

  // Working registers; only meaningful while CALC/DONE, so no reset needed.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    rem_q <= rem_d;
    den_q <= den_d;
    acc_q <= acc_d;
    dz_q  <= dz_d;
    ov_q  <= ov_d;
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign result_valid = rv_q;
  assign quotient     = quot_q;
  assign remainder    = remo_q;
  assign div_by_zero  = dzo_q;
  assign overflow     = ovo_q;

endmodule

// File: tb/tb_seq_frac_divider.sv
// Directed and randomized bench for seq_frac_divider at DW=16, QW=8.
module tb_seq_frac_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        start_ready;
  logic        busy;
  logic        result_valid;
  logic [7:0]  quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [7:0]  q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[12];

  seq_frac_divider #(.DW(16), .QW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .start_ready  (start_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one division and wait for its result; lat = edges from acceptance
  // to the first result_valid sample (0 if it never came).
  task automatic run_one(input logic [15:0] n, input logic [15:0] d, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'hBEEF;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int e;
    int j;
    int p;
    int acc_edge[3];
    logic [15:0] rn, rd;
    logic [31:0] mq, mr;
    logic mdz, mov;

    vecs[0]  = '{16'd22000, 16'd22727, 8'd247, 16'd18431, 1'b0, 1'b0};
    vecs[1]  = '{16'd11363, 16'd22727, 8'd127, 16'd22599, 1'b0, 1'b0};
    vecs[2]  = '{16'd22727, 16'd22727, 8'd255, 16'd0,     1'b0, 1'b1};
    vecs[3]  = '{16'd0,     16'd22727, 8'd0,   16'd0,     1'b0, 1'b0};
    vecs[4]  = '{16'd1000,  16'd0,     8'd255, 16'd0,     1'b1, 1'b0};
    vecs[5]  = '{16'd1,     16'd2,     8'd128, 16'd0,     1'b0, 1'b0};
    vecs[6]  = '{16'd1,     16'd3,     8'd85,  16'd1,     1'b0, 1'b0};
    vecs[7]  = '{16'd65534, 16'd65535, 8'd255, 16'd65279, 1'b0, 1'b0};
    vecs[8]  = '{16'd1,     16'd65535, 8'd0,   16'd256,   1'b0, 1'b0};
    vecs[9]  = '{16'd3,     16'd7,     8'd109, 16'd5,     1'b0, 1'b0};
    vecs[10] = '{16'd65535, 16'd0,     8'd255, 16'd0,     1'b1, 1'b0};
    vecs[11] = '{16'd40000, 16'd100,   8'd255, 16'd0,     1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset quotient",     quotient, 0);
    chk("reset remainder",    remainder, 0);
    chk("reset flags",        {div_by_zero, overflow, result_valid, busy}, 0);
    chk("reset start_ready",  start_ready, 1);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].n, vecs[i].d, lat);
      chk($sformatf("latency[%0d]", i),   lat, 9);
      chk($sformatf("quotient[%0d]", i),  quotient, vecs[i].q);
      chk($sformatf("remainder[%0d]", i), remainder, vecs[i].r);
      chk($sformatf("flags[%0d]", i),     {div_by_zero, overflow}, {vecs[i].dz, vecs[i].ov});
      chk($sformatf("ready_at_valid[%0d]", i), {start_ready, busy}, 2'b10);
      @(posedge clk); #1;
      chk($sformatf("valid_one_cycle[%0d]", i), result_valid, 0);
      chk($sformatf("held_quotient[%0d]", i), quotient, vecs[i].q);
    end

    // Reset in the middle of CALC aborts the division.
    @(negedge clk);
    start = 1'b1; dividend = 16'd3; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midcalc busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midcalc reset outputs", {quotient, remainder, div_by_zero, overflow, result_valid, busy}, 0);
    chk("midcalc reset ready", start_ready, 1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    chk("no pulse after reset", pulses, 0);

    // rst and start on the same edge: nothing accepted.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 16'd1; divisor = 16'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst beats start", {start_ready, busy}, 2'b10);

    // start held high; operands change while busy.
    e = 0; j = 0; p = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (start_ready) begin
        if (j < 3) begin
          start = 1'b1;
          dividend = vecs[j].n;
          divisor  = vecs[j].d;
          acc_edge[j] = e + 1;
          j++;
        end else begin
          start = 1'b0;
        end
      end else begin
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      @(posedge clk); e++; #1;
      if (result_valid) begin
        if (p < 3) begin
          chk($sformatf("b2b quotient[%0d]", p),  quotient, vecs[p].q);
          chk($sformatf("b2b remainder[%0d]", p), remainder, vecs[p].r);
          chk($sformatf("b2b latency[%0d]", p),   e - acc_edge[p], 9);
        end
        p++;
      end
    end
    start = 1'b0;
    chk("b2b pulses", p, 3);
    chk("b2b spacing01", acc_edge[1] - acc_edge[0], 10);
    chk("b2b spacing12", acc_edge[2] - acc_edge[1], 10);

    // Randomized sweep against a reference model.
    for (int i = 0; i < 1000; i++) begin
      rd = 16'($urandom);
      if (i % 16 == 0) rd = 16'd0;
      if (i % 4 == 0) rn = 16'($urandom);
      else rn = 16'($urandom_range(0, (rd == 0) ? 0 : int'(rd) - 1));
      if (rd == 0) begin
        mdz = 1'b1; mov = 1'b0; mq = 255; mr = 0;
      end else if (rn >= rd) begin
        mdz = 1'b0; mov = 1'b1; mq = 255; mr = 0;
      end else begin
        mdz = 1'b0; mov = 1'b0;
        mq = ({16'd0, rn} * 32'd256) / {16'd0, rd};
        mr = ({16'd0, rn} * 32'd256) % {16'd0, rd};
      end
      run_one(rn, rd, lat);
      chk($sformatf("rand[%0d] n=%0d d=%0d", i, rn, rd),
          {lat[3:0], quotient, remainder, div_by_zero, overflow},
          {4'd9, mq[7:0], mr[15:0], mdz, mov});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
